pcileech_com_tx_arbiter: RTL

//  Round-robin arbiter sharing the single FIFO-CTL -> COM (FT601) transmit word stream between NUM_SRC producers
//  (e.g. PCIe TLP rx, PCIe cfg rx, FIFO-CTL status/loopback). Grants one source per packet and forwards its words

---
 rtl/pcileech_com_tx_arbiter_if.sv | 41 ++++
 rtl/pcileech_com_tx_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pcileech_com_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_com_tx_arbiter_if
// Purpose  : Bundles the producer-side word streams and the single COM-side
//            word stream of the transmit arbiter.
//   src_valid / src_data / src_last : per-producer word offer (source i word
//                                     at src_data[i*DATA_W +: DATA_W])
//   src_ready                       : per-producer accept, one-hot or zero
//   dst_valid / dst_data / dst_last : forwarded word toward COM
//   dst_src_id                      : index of the granted producer
//   dst_ready                       : COM side accepts the word
//   Modport master = arbiter side, modport slave = producers + COM side.
// Revision : 1.0 - initial release
// ============================================================================
interface pcileech_com_tx_arbiter_if #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 32
);
    localparam int ID_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_last;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      dst_valid;
    logic [DATA_W-1:0]         dst_data;
    logic                      dst_last;
    logic [ID_W-1:0]           dst_src_id;
    logic                      dst_ready;

    modport master (
        input  src_valid, src_data, src_last, dst_ready,
        output src_ready, dst_valid, dst_data, dst_last, dst_src_id
    );

    modport slave (
        output src_valid, src_data, src_last, dst_ready,
        input  src_ready, dst_valid, dst_data, dst_last, dst_src_id
    );
endinterface
`default_nettype wire

// File: rtl/pcileech_com_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcileech_com_tx_arbiter
// Purpose  : Round-robin arbiter sharing the FIFO-CTL -> COM transmit word
//            stream between NUM_SRC producers. One producer is granted per
//            packet; grants are cut after MAX_BURST words and revoked by a
//            watchdog if the granted producer stalls for IDLE_TIMEOUT cycles.
// Ports    :
//   clk        system clock
//   rst_n      asynchronous reset, active-low
//   bus        pcileech_com_tx_arbiter_if.master (producer and COM streams)
//   busy       a grant is held
//   timeout_p  one-cycle pulse when the watchdog revokes a grant
// Revision : 1.0 - initial release
// ============================================================================
module pcileech_com_tx_arbiter #(
    parameter int NUM_SRC      = 3,
    parameter int DATA_W       = 32,
    parameter int MAX_BURST    = 256,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    pcileech_com_tx_arbiter_if.master        bus,
    output logic                             busy,
    output logic                             timeout_p
);
    localparam int ID_W = $clog2(NUM_SRC);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int IC_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   rr_ptr;
    logic [BC_W-1:0]   burst_cnt;
    logic [IC_W-1:0]   idle_cnt;

    logic [ID_W-1:0]   pick;
    logic              pick_found;
    logic [ID_W-1:0]   grant_inc;
    logic [DATA_W-1:0] data_arr [NUM_SRC];
    logic              sel_valid;
    logic              sel_last;
    logic              beat;
    logic              cap_hit;
    logic              end_grant;
    logic              stall_expire;

    // (base + off) mod NUM_SRC, with off < NUM_SRC
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        return ID_W'(sum);
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign data_arr[i] = bus.src_data[i*DATA_W +: DATA_W];
    end

    // Scan from the farthest offset down so the offset closest to rr_ptr wins.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.src_valid[rr_idx(rr_ptr, i)]) begin
                pick       = rr_idx(rr_ptr, i);
                pick_found = 1'b1;
            end
        end
    end

    assign grant_inc    = rr_idx(grant, 1);
    assign sel_valid    = bus.src_valid[grant];
    assign sel_last     = bus.src_last[grant];
    assign beat         = (state == S_GRANT) && sel_valid && bus.dst_ready;
    assign cap_hit      = (burst_cnt == BC_W'(MAX_BURST - 1));
    // End of packet and burst cap on the same beat collapse into one release.
    assign end_grant    = beat && (sel_last || cap_hit);
    // Backpressure with valid held is not a stall; only missing valid counts.
    assign stall_expire = (state == S_GRANT) && !sel_valid &&
                          (idle_cnt == IC_W'(IDLE_TIMEOUT - 1));

    // State register and grant bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                burst_cnt <= '0;
                idle_cnt  <= '0;
                if (pick_found) grant <= pick;
            end else if (end_grant || stall_expire) begin
                rr_ptr    <= grant_inc;
                burst_cnt <= '0;
                idle_cnt  <= '0;
            end else begin
                if (beat) burst_cnt <= burst_cnt + BC_W'(1);
                if (sel_valid) idle_cnt <= '0;
                else           idle_cnt <= idle_cnt + IC_W'(1);
            end
        end
    end

    // Next-state logic; leaving GRANT always passes through one IDLE bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_found) state_nxt = S_GRANT;
            S_GRANT: if (end_grant || stall_expire) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: combinational datapath mux from the registered grant.
    always_comb begin
        bus.src_ready  = '0;
        bus.dst_valid  = 1'b0;
        bus.dst_data   = '0;
        bus.dst_last   = 1'b0;
        bus.dst_src_id = '0;
        busy           = 1'b0;
        timeout_p      = 1'b0;
        if (state == S_GRANT) begin
            bus.src_ready[grant] = bus.dst_ready;
            bus.dst_valid        = sel_valid;
            bus.dst_data         = data_arr[grant];
            bus.dst_last         = sel_last;
            bus.dst_src_id       = grant;
            busy                 = 1'b1;
            timeout_p            = stall_expire;
        end
    end
endmodule
`default_nettype wire
